// File: rtl/mem_stage_lsu_pkg.sv
// Shared types, funct3 encodings and access helpers for the load/store memory stage.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W} mem_size_e;
  typedef enum logic {IDLE, ACCESS} lsu_state_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
  } inst_decoded_t;

  // A set mem_write wins over mem_read, so the funct3 is judged as a store encoding.
  function automatic logic op_supported(logic rd, logic wr, logic [2:0] f3);
    if (wr) return f3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
    if (rd) return f3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
    return 1'b0;
  endfunction

  function automatic mem_size_e size_of(logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return MEM_B;
      3'b001, 3'b101: return MEM_H;
      default:        return MEM_W;
    endcase
  endfunction

  function automatic logic is_misaligned(mem_size_e size, logic [1:0] off);
    case (size)
      MEM_H:   return off[0];
      MEM_W:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(logic [2:0] f3, logic [1:0] off, logic [31:0] word);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (f3)
      FUNCT3_LB:  return {{24{lane[7]}}, lane[7:0]};
      FUNCT3_LH:  return {{16{lane[15]}}, lane[15:0]};
      FUNCT3_LBU: return {24'h0, lane[7:0]};
      FUNCT3_LHU: return {16'h0, lane[15:0]};
      default:    return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_dmem_bram.sv
// Word-organised data RAM: one synchronous read port, one byte-enabled write port,
// write-first when both ports hit the same word in the same cycle.
module mem_stage_lsu_dmem_bram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] fwd;

  always_comb begin
    fwd = mem[raddr];
    for (int i = 0; i < 4; i++) begin
      if (we && be[i] && (waddr == raddr)) fwd[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Read data only updates on a read, so a held load result stays put.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= fwd;
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: byte-enabled loads/stores into a local data RAM with a configurable
// access latency, misalignment detection and backpressure towards execute.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  inst_decoded_t inst_mem_in,
  input  logic          stall_mem_in,
  output logic          stall_mem_out,
  output logic          valid_out,
  output inst_decoded_t inst_mem_out,
  output logic          misalign_out
);

  localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 2);
  localparam bit         SINGLE   = (MEM_LATENCY == 1);

  lsu_state_e    state, state_next;
  logic [2:0]    cnt, cnt_next;
  inst_decoded_t pend, cur, out_inst;
  logic          out_load, out_mis;
  logic          out_blocked, accept, go, new_result;
  logic          cur_mem, cur_store, cur_load, cur_mis;
  mem_size_e     cur_size;
  logic [3:0]    be;
  logic [31:0]   wdata, rdata;
  logic          we, re;

  assign out_blocked   = valid_out & stall_mem_in;
  assign stall_mem_out = (state == ACCESS) | out_blocked;
  assign accept        = valid_in & ~stall_mem_out;

  // Multi-cycle accesses work from the latched copy since execute moves on after accept.
  assign cur       = (state == ACCESS) ? pend : inst_mem_in;
  assign cur_mem   = op_supported(cur.mem_read, cur.mem_write, cur.funct3);
  assign cur_store = cur_mem & cur.mem_write;
  assign cur_load  = cur_mem & ~cur.mem_write;
  assign cur_size  = size_of(cur.funct3);
  assign cur_mis   = cur_mem & is_misaligned(cur_size, cur.alu_result[1:0]);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    go         = 1'b0;
    new_result = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cur_mem && !SINGLE) begin
            state_next = ACCESS;
            cnt_next   = '0;
          end else begin
            new_result = 1'b1;
            go         = cur_mem;
          end
        end
      end
      ACCESS: begin
        if (cnt == LAST_CNT) begin
          if (!out_blocked) begin
            go         = 1'b1;
            new_result = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = cur.rs2_data;
    case (cur_size)
      MEM_B: begin
        be    = 4'b0001 << cur.alu_result[1:0];
        wdata = {4{cur.rs2_data[7:0]}};
      end
      MEM_H: begin
        be    = 4'b0011 << cur.alu_result[1:0];
        wdata = {2{cur.rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign we = go & cur_store & ~cur_mis;
  assign re = go & cur_load & ~cur_mis;

  mem_stage_lsu_dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_dmem (
    .clk  (clk),
    .we   (we),
    .be   (be),
    .waddr(cur.alu_result[ADDR_W+1:2]),
    .wdata(wdata),
    .re   (re),
    .raddr(cur.alu_result[ADDR_W+1:2]),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= '0;
      valid_out <= 1'b0;
      out_inst  <= '0;
      out_mis   <= 1'b0;
      out_load  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && accept) pend <= inst_mem_in;
      if (new_result) begin
        valid_out <= 1'b1;
        out_inst  <= cur;
        out_mis   <= cur_mis;
        out_load  <= cur_load & ~cur_mis;
        if (cur_mis) out_inst.wb_data <= '0;
      end else if (!out_blocked) begin
        valid_out <= 1'b0;
      end
    end
  end

  // Load extension sits after the RAM's read register so a load still fits one cycle.
  always_comb begin
    inst_mem_out = out_inst;
    if (out_load) inst_mem_out.wb_data = load_extend(out_inst.funct3, out_inst.alu_result[1:0], rdata);
  end

  assign misalign_out = out_mis;

endmodule
